wb_commit_queue: RTL and testbench
==================================

Name: wb_commit_queue

Overview:
- Write-side initiator for the 32x32 register bank. It accepts results from the execute/memory path over a valid/ready handshake and buffers them in a small FIFO.
- It drains one entry per clock onto the bank write port (RegEscr, EscrReg, datain).
- It forwards pending (not yet committed) values to the bank read addresses RegLe1/RegLe2, so the core never reads a stale register.
- It sits between the ALU/data-memory result mux and bankregister.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 6, register address width (matches bank port width)
- DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- res_valid  in  1  result offered
- res_ready  out  1  queue can accept
- res_we  in  1  result must be written (0 = accepted and discarded)
- res_dest  in  ADDR_W  destination register
- res_data  in  DATA_W  result value
- hold  in  1  bank busy; suppress commit this cycle
- RegEscr  out  ADDR_W  bank write address
- EscrReg  out  1  bank write enable
- datain  out  DATA_W  bank write data
- RegLe1  in  ADDR_W  bank read address 1 (snooped)
- RegLe2  in  ADDR_W  bank read address 2 (snooped)
- fwd1_hit  out  1  pending value exists for RegLe1
- fwd1_data  out  DATA_W  youngest pending value for RegLe1
- fwd2_hit  out  1  pending value exists for RegLe2
- fwd2_data  out  DATA_W  youngest pending value for RegLe2
- empty  out  1  no pending entries
- count  out  clog2(DEPTH)+1  occupancy

Behaviour:
- Reset is asynchronous on rst_n low. Pointers and count go to 0, all entry valid bits clear, state IDLE.
- Reset outputs: res_ready=1, EscrReg=0, RegEscr=0, datain=0, fwd*_hit=0, fwd*_data=0, empty=1, count=0.
- Accept happens at a rising edge when res_valid && res_ready.
- An entry is enqueued only if res_we=1 and res_dest!=0. Writes to register 0 and res_we=0 results are accepted and dropped; they never occupy a slot.
- res_ready = (count<DEPTH), combinational from state only. It never depends on res_valid, and there is no same-cycle pass-through when full.
- Commit outputs come combinationally from the FIFO head flops:
  - EscrReg = !empty && !hold && state==RUN.
  - RegEscr/datain = head entry, or 0 when empty.
- Pop occurs at the same edge the bank samples EscrReg=1. This gives exactly one commit per cycle.
- Latency: a result accepted at edge N into an empty queue shows EscrReg=1 after edge N and is written to the bank at edge N+1 (if hold=0).
- Simultaneous push and pop: allowed whenever count<DEPTH; count is unchanged. When full, a pop frees the slot for the next edge only.
- Wrap-around: pointers are modulo DEPTH. count disambiguates full from empty.
- State machine:
  - IDLE (empty): goes to RUN on an enqueue.
  - RUN: commits while hold=0. Goes to IDLE when the last entry pops with no simultaneous enqueue.
  - hold=1 in RUN freezes head and pointers. Enqueue still allowed if not full.
- Forwarding:
  - fwdK_hit=1 if any valid entry (head included) has dest==RegLeK and RegLeK!=0.
  - fwdK_data is the youngest such entry (closest to tail). Otherwise fwdK_data=0.
  - Fully combinational; the entry being committed this cycle still forwards.
  - An incoming result in the same cycle does not forward; it is visible from the next cycle.
- Duplicate destinations are allowed. Entries commit in order, so the bank ends with the youngest value.
- Reset mid-operation discards all pending entries. No bank write is issued during or after reset until a new accept.

Decomposition:
- Shared package wb_pkg:
  - WB_DATA_W=32, WB_ADDR_W=6, WB_ZERO_REG=0.
  - Entry struct {dest, data}.
  - State enum {WB_IDLE, WB_RUN}.
- One natural sub-module: wb_fwd_match, the parametric youngest-match priority search over entries. It is instantiated twice, once per read address.
- FIFO storage and control stay in the top.

Test Plan:
- Reset then single accept (dest=5, data=0xDEADBEEF, hold=0) -> EscrReg=1, RegEscr=5, datain=0xDEADBEEF for one cycle; next cycle empty=1, EscrReg=0.
- Offer dest=0, data=0x1234, and a result with res_we=0 -> both accepted (res_ready=1), count stays 0, EscrReg never asserts.
- hold=1 while enqueuing 4 results (dest 1..4) -> count=4, res_ready=0, 5th result stalls. Release hold -> commits to regs 1,2,3,4 in order on 4 consecutive cycles, then the 5th is accepted.
- Enqueue dest=7 value 0x11, then dest=7 value 0x22 with hold=1, and RegLe1=7 -> fwd1_hit=1, fwd1_data=0x22. RegLe2=0 -> fwd2_hit=0. After drain, bank reg7=0x22.
- Continuous valid stream of 10 results with hold=0 -> one accept and one commit per cycle, count constant at 1. Pointers wrap twice with no loss or reorder.
- rst_n low asynchronously with count=3 mid-cycle -> outputs reset immediately (EscrReg=0, empty=1). After release, no residual write occurs.

Source files
------------

// File: rtl/wb_pkg.sv
// ============================================================
// Package : wb_pkg -- shared types/constants for the commit queue
// Rev     : 1.0
// ============================================================
`default_nettype none

package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 6;
    localparam logic [WB_ADDR_W-1:0] WB_ZERO_REG = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_RUN  = 1'b1
    } wb_state_e;

    // Occupancy needs one bit more than the pointers so "full" is representable.
    function automatic int wb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_commit_queue_if.sv
// ============================================================
// Interface : wb_commit_queue_if -- result handshake, bank port, snoop
// Rev       : 1.0
// ============================================================
`default_nettype none

interface wb_commit_queue_if
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) ();

    localparam int CNT_W = wb_cnt_w(DEPTH);

    logic              res_valid;
    logic              res_ready;
    logic              res_we;
    logic [ADDR_W-1:0] res_dest;
    logic [DATA_W-1:0] res_data;
    logic              hold;
    logic [ADDR_W-1:0] RegEscr;
    logic              EscrReg;
    logic [DATA_W-1:0] datain;
    logic [ADDR_W-1:0] RegLe1;
    logic [ADDR_W-1:0] RegLe2;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  res_valid, res_we, res_dest, res_data, hold, RegLe1, RegLe2,
        output res_ready, RegEscr, EscrReg, datain,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, empty, count
    );

    modport master (
        output res_valid, res_we, res_dest, res_data, hold, RegLe1, RegLe2,
        input  res_ready, RegEscr, EscrReg, datain,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, empty, count
    );

endinterface

`default_nettype wire

// File: rtl/wb_fwd_match.sv
// ============================================================
// Module : wb_fwd_match -- youngest-match search over age-ordered entries
// Rev    : 1.0
// ============================================================
`default_nettype none

module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic [DEPTH-1:0]             ent_vld,
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_dest,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [ADDR_W-1:0]            addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data
);

    // Index 0 is the oldest entry; later matches override earlier ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_dest[i] == addr) && (addr != ADDR_W'(WB_ZERO_REG))) begin
                hit      = 1'b1;
                hit_data = ent_data[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_commit_queue.sv
// ============================================================
// Module : wb_commit_queue -- buffered register-bank write initiator
// Rev    : 1.0
// ============================================================
`default_nettype none

module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_commit_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = wb_cnt_w(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    wb_state_e        state;

    logic ready;
    logic is_empty;
    logic push;
    logic pop;

    assign ready    = (cnt < CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);
    // Register 0 and non-writing results are acknowledged but never stored.
    assign push     = bus.res_valid && ready && bus.res_we
                      && (bus.res_dest != ADDR_W'(WB_ZERO_REG));
    assign pop      = !is_empty && !bus.hold && (state == WB_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            state <= WB_IDLE;
        end else begin
            if (push) begin
                mem[tail] <= '{dest: bus.res_dest, data: bus.res_data};
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            case (state)
                WB_IDLE: if (push) state <= WB_RUN;
                WB_RUN:  if (pop && !push && (cnt == CNT_W'(1))) state <= WB_IDLE;
                default: state <= WB_IDLE;
            endcase
        end
    end

    assign bus.res_ready = ready;
    assign bus.EscrReg   = pop;
    assign bus.RegEscr   = is_empty ? '0 : mem[head].dest;
    assign bus.datain    = is_empty ? '0 : mem[head].data;
    assign bus.empty     = is_empty;
    assign bus.count     = cnt;

    // Present entries oldest-first so the matcher's last hit is the youngest.
    logic [DEPTH-1:0]             ord_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] ord_dest;
    logic [DEPTH-1:0][DATA_W-1:0] ord_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        logic [PTR_W-1:0] idx;
        assign idx         = head + PTR_W'(i);
        assign ord_vld[i]  = vld[idx];
        assign ord_dest[i] = mem[idx].dest;
        assign ord_data[i] = mem[idx].data;
    end

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd1 (
        .ent_vld  (ord_vld),
        .ent_dest (ord_dest),
        .ent_data (ord_data),
        .addr     (bus.RegLe1),
        .hit      (bus.fwd1_hit),
        .hit_data (bus.fwd1_data)
    );

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd2 (
        .ent_vld  (ord_vld),
        .ent_dest (ord_dest),
        .ent_data (ord_data),
        .addr     (bus.RegLe2),
        .hit      (bus.fwd2_hit),
        .hit_data (bus.fwd2_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
// ============================================================
// Testbench : tb_wb_commit_queue -- directed scenarios for the commit queue
// Rev       : 1.0
// ============================================================
`default_nettype none

module tb_wb_commit_queue;
    import wb_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    wb_commit_queue_if #(.DATA_W(32), .ADDR_W(6), .DEPTH(4)) ifc ();

    wb_commit_queue #(.DATA_W(32), .ADDR_W(6), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: records every write the queue issues.
    logic [31:0] bank [64];
    wb_entry_t   log_q [$];

    always @(posedge clk) begin
        if (ifc.EscrReg) begin
            bank[ifc.RegEscr] = ifc.datain;
            log_q.push_back('{dest: ifc.RegEscr, data: ifc.datain});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        ifc.res_valid = 1'b0;
        ifc.res_we    = 1'b0;
        ifc.res_dest  = '0;
        ifc.res_data  = '0;
        ifc.hold      = 1'b0;
        ifc.RegLe1    = 6'd0;
        ifc.RegLe2    = 6'd0;
        #12;
        checks++; if (ifc.res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ifc.res_ready); end
        checks++; if (ifc.EscrReg !== 1'b0) begin errors++; $display("FAIL reset_escr got %b exp 0", ifc.EscrReg); end
        checks++; if (ifc.RegEscr !== 6'd0) begin errors++; $display("FAIL reset_regescr got %h exp 0", ifc.RegEscr); end
        checks++; if (ifc.datain !== 32'd0) begin errors++; $display("FAIL reset_datain got %h exp 0", ifc.datain); end
        checks++; if (ifc.fwd1_hit !== 1'b0 || ifc.fwd2_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got %b%b exp 00", ifc.fwd1_hit, ifc.fwd2_hit); end
        checks++; if (ifc.fwd1_data !== 32'd0 || ifc.fwd2_data !== 32'd0) begin errors++; $display("FAIL reset_fwd_data got %h %h exp 0 0", ifc.fwd1_data, ifc.fwd2_data); end
        checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", ifc.empty); end
        checks++; if (ifc.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ifc.count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ifc.res_valid = 1'b1;
        ifc.res_we    = 1'b1;
        ifc.res_dest  = 6'd5;
        ifc.res_data  = 32'hDEADBEEF;
        ifc.hold      = 1'b0;
        tick();
        ifc.res_valid = 1'b0;
        #1;
        checks++; if (ifc.EscrReg !== 1'b1) begin errors++; $display("FAIL single_escr got %b exp 1", ifc.EscrReg); end
        checks++; if (ifc.RegEscr !== 6'd5) begin errors++; $display("FAIL single_regescr got %0d exp 5", ifc.RegEscr); end
        checks++; if (ifc.datain !== 32'hDEADBEEF) begin errors++; $display("FAIL single_datain got %h exp deadbeef", ifc.datain); end
        checks++; if (ifc.count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", ifc.count); end
        tick();
        checks++; if (ifc.empty !== 1'b1 || ifc.EscrReg !== 1'b0) begin errors++; $display("FAIL single_drained got empty=%b escr=%b exp 1 0", ifc.empty, ifc.EscrReg); end
        checks++; if (bank[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_bank5 got %h exp deadbeef", bank[5]); end
    endtask

    task automatic test_drop();
        int n0;
        n0 = log_q.size();
        ifc.res_valid = 1'b1;
        ifc.res_we    = 1'b1;
        ifc.res_dest  = 6'd0;
        ifc.res_data  = 32'h1234;
        #1;
        checks++; if (ifc.res_ready !== 1'b1) begin errors++; $display("FAIL drop_r0_ready got %b exp 1", ifc.res_ready); end
        tick();
        checks++; if (ifc.count !== 3'd0 || ifc.EscrReg !== 1'b0) begin errors++; $display("FAIL drop_r0 got count=%0d escr=%b exp 0 0", ifc.count, ifc.EscrReg); end
        ifc.res_we   = 1'b0;
        ifc.res_dest = 6'd3;
        #1;
        checks++; if (ifc.res_ready !== 1'b1) begin errors++; $display("FAIL drop_we0_ready got %b exp 1", ifc.res_ready); end
        tick();
        ifc.res_valid = 1'b0;
        ifc.res_we    = 1'b1;
        checks++; if (ifc.count !== 3'd0 || ifc.EscrReg !== 1'b0) begin errors++; $display("FAIL drop_we0 got count=%0d escr=%b exp 0 0", ifc.count, ifc.EscrReg); end
        tick();
        checks++; if (log_q.size() !== n0) begin errors++; $display("FAIL drop_no_write got %0d writes exp 0", log_q.size() - n0); end
    endtask

    task automatic test_full_hold();
        logic [5:0]  ed [5] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd9};
        logic [31:0] ev [5] = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h999};
        logic        acc;
        ifc.hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ifc.res_valid = 1'b1;
            ifc.res_dest  = 6'(k + 1);
            ifc.res_data  = 32'h101 + 32'(k);
            tick();
        end
        ifc.res_dest = 6'd9;
        ifc.res_data = 32'h999;
        #1;
        checks++; if (ifc.count !== 3'd4 || ifc.res_ready !== 1'b0) begin errors++; $display("FAIL full_state got count=%0d ready=%b exp 4 0", ifc.count, ifc.res_ready); end
        checks++; if (ifc.EscrReg !== 1'b0) begin errors++; $display("FAIL full_hold_escr got %b exp 0", ifc.EscrReg); end
        tick();
        checks++; if (ifc.count !== 3'd4) begin errors++; $display("FAIL full_stall got count=%0d exp 4", ifc.count); end
        ifc.hold = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (ifc.EscrReg !== 1'b1 || ifc.RegEscr !== ed[j] || ifc.datain !== ev[j]) begin
                errors++;
                $display("FAIL full_commit%0d got escr=%b reg=%0d data=%h exp 1 %0d %h", j, ifc.EscrReg, ifc.RegEscr, ifc.datain, ed[j], ev[j]);
            end
            if (j == 0) begin
                checks++; if (ifc.res_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru got ready=%b exp 0", ifc.res_ready); end
            end
            acc = ifc.res_valid && ifc.res_ready;
            tick();
            if (acc) ifc.res_valid = 1'b0;
        end
        checks++; if (ifc.empty !== 1'b1 || ifc.res_valid !== 1'b0) begin errors++; $display("FAIL full_drained got empty=%b pending_valid=%b exp 1 0", ifc.empty, ifc.res_valid); end
    endtask

    task automatic test_forward();
        ifc.hold      = 1'b1;
        ifc.RegLe1    = 6'd7;
        ifc.RegLe2    = 6'd0;
        ifc.res_valid = 1'b1;
        ifc.res_dest  = 6'd7;
        ifc.res_data  = 32'h11;
        #1;
        checks++; if (ifc.fwd1_hit !== 1'b0) begin errors++; $display("FAIL fwd_incoming got hit=%b exp 0", ifc.fwd1_hit); end
        tick();
        checks++; if (ifc.fwd1_hit !== 1'b1 || ifc.fwd1_data !== 32'h11) begin errors++; $display("FAIL fwd_first got hit=%b data=%h exp 1 11", ifc.fwd1_hit, ifc.fwd1_data); end
        ifc.res_data = 32'h22;
        tick();
        ifc.res_valid = 1'b0;
        #1;
        checks++; if (ifc.fwd1_hit !== 1'b1 || ifc.fwd1_data !== 32'h22) begin errors++; $display("FAIL fwd_youngest got hit=%b data=%h exp 1 22", ifc.fwd1_hit, ifc.fwd1_data); end
        checks++; if (ifc.fwd2_hit !== 1'b0 || ifc.fwd2_data !== 32'h0) begin errors++; $display("FAIL fwd_reg0 got hit=%b data=%h exp 0 0", ifc.fwd2_hit, ifc.fwd2_data); end
        ifc.RegLe2 = 6'd7;
        #1;
        checks++; if (ifc.fwd2_hit !== 1'b1 || ifc.fwd2_data !== 32'h22) begin errors++; $display("FAIL fwd_port2 got hit=%b data=%h exp 1 22", ifc.fwd2_hit, ifc.fwd2_data); end
        ifc.hold = 1'b0;
        tick();
        checks++; if (ifc.fwd1_hit !== 1'b1 || ifc.fwd1_data !== 32'h22 || ifc.EscrReg !== 1'b1) begin errors++; $display("FAIL fwd_head got hit=%b data=%h escr=%b exp 1 22 1", ifc.fwd1_hit, ifc.fwd1_data, ifc.EscrReg); end
        tick();
        checks++; if (bank[7] !== 32'h22) begin errors++; $display("FAIL fwd_bank7 got %h exp 22", bank[7]); end
        checks++; if (ifc.fwd1_hit !== 1'b0 || ifc.empty !== 1'b1) begin errors++; $display("FAIL fwd_after_drain got hit=%b empty=%b exp 0 1", ifc.fwd1_hit, ifc.empty); end
        ifc.RegLe1 = 6'd0;
        ifc.RegLe2 = 6'd0;
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = log_q.size();
        ifc.hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ifc.res_valid = 1'b1;
            ifc.res_dest  = 6'(10 + k);
            ifc.res_data  = 32'hA0 + 32'(k);
            tick();
            checks++;
            if (ifc.count !== 3'd1 || ifc.EscrReg !== 1'b1 || ifc.RegEscr !== 6'(10 + k)) begin
                errors++;
                $display("FAIL stream%0d got count=%0d escr=%b reg=%0d exp 1 1 %0d", k, ifc.count, ifc.EscrReg, ifc.RegEscr, 10 + k);
            end
        end
        ifc.res_valid = 1'b0;
        tick();
        checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b exp 1", ifc.empty); end
        checks++; if (log_q.size() - n0 !== 10) begin errors++; $display("FAIL stream_nwrites got %0d exp 10", log_q.size() - n0); end
        for (int i = 0; i < 10 && (n0 + i) < log_q.size(); i++) begin
            checks++;
            if (log_q[n0 + i].dest !== 6'(10 + i) || log_q[n0 + i].data !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL stream_order%0d got %0d/%h exp %0d/%h", i, log_q[n0 + i].dest, log_q[n0 + i].data, 10 + i, 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_async_reset();
        int n0;
        ifc.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ifc.res_valid = 1'b1;
            ifc.res_dest  = 6'(20 + k);
            ifc.res_data  = 32'h500 + 32'(k);
            tick();
        end
        ifc.res_valid = 1'b0;
        checks++; if (ifc.count !== 3'd3) begin errors++; $display("FAIL areset_pre got count=%0d exp 3", ifc.count); end
        n0 = log_q.size();
        #2;
        ifc.hold = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++; if (ifc.EscrReg !== 1'b0 || ifc.empty !== 1'b1 || ifc.count !== 3'd0) begin errors++; $display("FAIL areset_now got escr=%b empty=%b count=%0d exp 0 1 0", ifc.EscrReg, ifc.empty, ifc.count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (log_q.size() !== n0) begin errors++; $display("FAIL areset_residual got %0d writes exp 0", log_q.size() - n0); end
        checks++; if (ifc.EscrReg !== 1'b0 || ifc.empty !== 1'b1) begin errors++; $display("FAIL areset_idle got escr=%b empty=%b exp 0 1", ifc.EscrReg, ifc.empty); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) bank[i] = '0;
        test_reset();
        test_single();
        test_drop();
        test_full_hold();
        test_forward();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
